// File: rtl/gray_ptr_ctrl.sv
// Gray-coded FIFO pointer controller for one side of an async FIFO (MODE 0 = write/full, MODE 1 = read/empty).
// Optional fill-level and almost flags are built when the GRAY_PTR_LEVEL_EN macro is defined.
module gray_ptr_ctrl #(
  parameter int PTR_SIZE  = 4,
  parameter int MODE      = 0,
  parameter int ALMOST_TH = 6
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                INC,
  input  logic [PTR_SIZE-1:0] SYNC_GRAY_PTR,
  output logic [PTR_SIZE-2:0] ADDR,
  output logic [PTR_SIZE-1:0] GRAY_PTR,
  output logic                FLAG
`ifdef GRAY_PTR_LEVEL_EN
  ,
  output logic [PTR_SIZE-1:0] LEVEL,
  output logic                ALMOST
`endif
);

  // Full is detected when the next pointer equals the other side's pointer with its top two Gray bits inverted.
  localparam logic [PTR_SIZE-1:0] TOP2_MASK = PTR_SIZE'(3) << (PTR_SIZE - 2);
  localparam logic                FLAG_RST  = (MODE != 0);

  logic [PTR_SIZE-1:0] bin_q, bin_d;
  logic [PTR_SIZE-1:0] gray_q, gray_d;
  logic                flag_q, flag_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bin_d = bin_q;
    if (INC && !flag_q) bin_d = bin_q + PTR_SIZE'(1);
    gray_d = bin_d ^ (bin_d >> 1);
    if (MODE == 0) flag_d = (gray_d == (SYNC_GRAY_PTR ^ TOP2_MASK));
    else           flag_d = (gray_d == SYNC_GRAY_PTR);
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bin_q  <= '0;
      gray_q <= '0;
      flag_q <= FLAG_RST;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      flag_q <= flag_d;
    end
  end

  assign ADDR     = bin_q[PTR_SIZE-2:0];
  assign GRAY_PTR = gray_q;
  assign FLAG     = flag_q;

`ifdef GRAY_PTR_LEVEL_EN
  localparam logic [PTR_SIZE-1:0] ALMOST_TH_W = PTR_SIZE'(ALMOST_TH);

  logic [PTR_SIZE-1:0] sync_bin;
  logic [PTR_SIZE-1:0] level_q, level_d;
  logic                almost_q, almost_d;

  always_comb begin
    sync_bin[PTR_SIZE-1] = SYNC_GRAY_PTR[PTR_SIZE-1];
    for (int i = PTR_SIZE - 2; i >= 0; i--) sync_bin[i] = sync_bin[i+1] ^ SYNC_GRAY_PTR[i];
  end

  // Level uses the next binary pointer so it lines up with FLAG on the same edge.
  always_comb begin
    if (MODE == 0) begin
      level_d  = bin_d - sync_bin;
      almost_d = (level_d >= ALMOST_TH_W);
    end else begin
      level_d  = sync_bin - bin_d;
      almost_d = (level_d <= ALMOST_TH_W);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      level_q  <= '0;
      almost_q <= 1'b0;
    end else begin
      level_q  <= level_d;
      almost_q <= almost_d;
    end
  end

  assign LEVEL  = level_q;
  assign ALMOST = almost_q;
`endif

endmodule
